fmr_fault_locator: RTL and testbench

Five-modular-redundancy (5MR) fault locator. It sits downstream of the five replica blocks, on the opposite end from fault injection: it majority-votes the replica outputs and identifies which replica (g1..g5 position) is misbehaving. A replica with persistent disagreement is masked out of the vote, and the system health state is reported to the supervisor.

---
 rtl/fmr_fault_locator_if.sv | 23 ++
 rtl/fmr_fault_locator.sv | 147 ++++++++++++++
 tb/tb_fmr_fault_locator.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fmr_fault_locator_if.sv
// Sample/status bundle between the five-replica datapath and the fault locator.
// master drives samples and reads status; slave is the locator itself.
interface fmr_fault_locator_if;
    logic       in_valid;
    logic [4:0] rep;
    logic       clr;
    logic       A;
    logic       out_valid;
    logic       tie;
    logic [4:0] fault;
    logic       new_fault;
    logic [1:0] state;

    modport master (
        output in_valid, rep, clr,
        input  A, out_valid, tie, fault, new_fault, state
    );

    modport slave (
        input  in_valid, rep, clr,
        output A, out_valid, tie, fault, new_fault, state
    );
endinterface

// File: rtl/fmr_fault_locator.sv
// 5MR fault locator: masked majority vote over five replicas, per-replica
// mismatch counters, latched fault mask and health state.
// Optional build macro FMR_RECOVERY_EN: faulty replicas that agree with the
// vote for RECOVER consecutive samples are reinstated.
//
// state    | meaning
// ---------+------------------------------------
// NORMAL   | no replica marked faulty
// DEGRADED | one or two replicas marked faulty
// FAILED   | three or more replicas marked faulty
module fmr_fault_locator #(
    parameter int THRESH  = 3,
    parameter int RECOVER = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fmr_fault_locator_if.slave bus
);
    localparam int CMAX = (THRESH > RECOVER) ? THRESH : RECOVER;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] THR = CW'(THRESH);
`ifdef FMR_RECOVERY_EN
    localparam logic [CW-1:0] REC = CW'(RECOVER);
`endif

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        DEGRADED = 2'b01,
        FAILED   = 2'b10
    } health_t;

    health_t       state_q, state_d;
    logic [4:0]    fault_q, fault_d;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic          a_q, a_d;
    logic          ov_q, ov_d;
    logic          tie_q, tie_d;
    logic          nf_q, nf_d;
    logic [2:0]    h, k;
    logic          is_tie, res;

    function automatic health_t derive(input logic [4:0] f);
        int n;
        n = 0;
        for (int i = 0; i < 5; i++) n = n + int'(f[i]);
        if (n == 0)      return NORMAL;
        else if (n <= 2) return DEGRADED;
        else             return FAILED;
    endfunction

    // Vote over the replicas that are healthy before this sample is applied.
    always_comb begin
        h = '0;
        k = '0;
        for (int i = 0; i < 5; i++) begin
            if (!fault_q[i]) begin
                h = h + 3'd1;
                if (bus.rep[i]) k = k + 3'd1;
            end
        end
        is_tie = ({k, 1'b0} == {1'b0, h});
        res    = ({k, 1'b0} >  {1'b0, h});
    end

    // Next-state: counters, fault mask, voted output and health state.
    always_comb begin
        fault_d = fault_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        ov_d    = 1'b0;
        tie_d   = 1'b0;
        nf_d    = 1'b0;
        state_d = state_q;
        if (bus.clr) begin
            fault_d = '0;
            for (int i = 0; i < 5; i++) cnt_d[i] = '0;
            state_d = NORMAL;
        end else if (bus.in_valid) begin
            ov_d = 1'b1;
            if (is_tie) begin
                tie_d = 1'b1;
            end else begin
                a_d = res;
                for (int i = 0; i < 5; i++) begin
                    if (!fault_q[i]) begin
                        if (bus.rep[i] != res) begin
                            if (cnt_q[i] + ONE == THR) begin
                                fault_d[i] = 1'b1;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + ONE;
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
`ifdef FMR_RECOVERY_EN
                    else begin
                        if (bus.rep[i] == res) begin
                            if (cnt_q[i] + ONE == REC) begin
                                fault_d[i] = 1'b0;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + ONE;
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
`endif
                end
                nf_d = |(fault_d & ~fault_q);
            end
            state_d = derive(fault_d);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            a_q     <= 1'b0;
            ov_q    <= 1'b0;
            tie_q   <= 1'b0;
            nf_q    <= 1'b0;
            state_q <= NORMAL;
        end else begin
            fault_q <= fault_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            a_q     <= a_d;
            ov_q    <= ov_d;
            tie_q   <= tie_d;
            nf_q    <= nf_d;
            state_q <= state_d;
        end
    end

    assign bus.A         = a_q;
    assign bus.out_valid = ov_q;
    assign bus.tie       = tie_q;
    assign bus.fault     = fault_q;
    assign bus.new_fault = nf_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_fmr_fault_locator.sv
// Directed bench for fmr_fault_locator (THRESH=3, RECOVER=8).
module tb_fmr_fault_locator;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    fmr_fault_locator_if bus();

    fmr_fault_locator #(.THRESH(3), .RECOVER(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic a, input logic ov, input logic t,
                           input logic [4:0] f, input logic nf, input logic [1:0] st);
        chk({tag, ".A"},         32'(bus.A),         32'(a));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".tie"},       32'(bus.tie),       32'(t));
        chk({tag, ".fault"},     32'(bus.fault),     32'(f));
        chk({tag, ".new_fault"}, 32'(bus.new_fault), 32'(nf));
        chk({tag, ".state"},     32'(bus.state),     32'(st));
    endtask

    task automatic step(input logic iv, input logic [4:0] r, input logic c);
        bus.in_valid = iv;
        bus.rep      = r;
        bus.clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.rep      = 5'b0;
        bus.clr      = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 5'b00000, 0, 2'b00);
        rst_n = 1'b1;

        // unanimous vote
        step(1, 5'b11111, 0);
        chk_out("unanimous", 1, 1, 0, 5'b00000, 0, 2'b00);
        step(0, 5'b00000, 0);
        chk_out("idle", 1, 0, 0, 5'b00000, 0, 2'b00);

        // replica g3 disagrees three times
        step(1, 5'b11011, 0);
        chk_out("g3_mis1", 1, 1, 0, 5'b00000, 0, 2'b00);
        step(1, 5'b11011, 0);
        chk_out("g3_mis2", 1, 1, 0, 5'b00000, 0, 2'b00);
        step(1, 5'b11011, 0);
        chk_out("g3_mis3", 1, 1, 0, 5'b00100, 1, 2'b01);
        step(0, 5'b11011, 0);
        chk_out("g3_idle", 1, 0, 0, 5'b00100, 0, 2'b01);
        step(1, 5'b11011, 1);
        chk_out("clr1", 1, 0, 0, 5'b00000, 0, 2'b00);

        // counter restart on agreement
        step(1, 5'b11011, 0);
        step(1, 5'b11011, 0);
        step(1, 5'b11111, 0);
        step(1, 5'b11011, 0);
        step(1, 5'b11011, 0);
        chk_out("restart", 1, 1, 0, 5'b00000, 0, 2'b00);
        step(1, 5'b11011, 0);
        chk_out("restart_3rd", 1, 1, 0, 5'b00100, 1, 2'b01);
        step(1, 5'b00000, 1);

        // establish fault on g1, then tie holds counters and A
        step(1, 5'b11110, 0);
        step(1, 5'b11110, 0);
        step(1, 5'b11110, 0);
        chk_out("g1_fault", 1, 1, 0, 5'b00001, 1, 2'b01);
        step(1, 5'b01110, 0);
        chk_out("g5_mis1", 1, 1, 0, 5'b00001, 0, 2'b01);
        step(1, 5'b00110, 0);
        chk_out("tie", 1, 1, 1, 5'b00001, 0, 2'b01);
        step(1, 5'b01110, 0);
        chk_out("g5_mis2", 1, 1, 0, 5'b00001, 0, 2'b01);
        step(1, 5'b01110, 0);
        chk_out("g5_mis3", 1, 1, 0, 5'b10001, 1, 2'b01);
        step(1, 5'b00000, 1);

        // two replicas fault on the same sample, then a third -> FAILED
        step(1, 5'b11100, 0);
        step(1, 5'b11100, 0);
        step(1, 5'b11100, 0);
        chk_out("dual_fault", 1, 1, 0, 5'b00011, 1, 2'b01);
        step(1, 5'b11000, 0);
        step(1, 5'b11000, 0);
        step(1, 5'b11000, 0);
        chk_out("failed", 1, 1, 0, 5'b00111, 1, 2'b10);
        step(1, 5'b00000, 0);
        chk_out("failed_vote0", 0, 1, 0, 5'b00111, 0, 2'b10);
        step(1, 5'b01000, 0);
        chk_out("failed_tie", 0, 1, 1, 5'b00111, 0, 2'b10);
        step(1, 5'b11000, 0);
        chk_out("failed_vote1", 1, 1, 0, 5'b00111, 0, 2'b10);
        step(1, 5'b00000, 1);
        chk_out("clr_prio", 1, 0, 0, 5'b00000, 0, 2'b00);

        // async reset drops a partial count on g5
        step(1, 5'b01111, 0);
        step(1, 5'b01111, 0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 5'b00000, 0, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 5'b01111, 0);
        chk_out("post_rst1", 1, 1, 0, 5'b00000, 0, 2'b00);
        step(1, 5'b01111, 0);
        step(1, 5'b01111, 0);
        chk_out("post_rst3", 1, 1, 0, 5'b10000, 1, 2'b01);

        // g5 faulty; it agrees with the vote for 7, then 8 samples
        repeat (7) step(1, 5'b11111, 0);
        chk_out("agree7", 1, 1, 0, 5'b10000, 0, 2'b01);
        step(1, 5'b11111, 0);
`ifdef FMR_RECOVERY_EN
        chk_out("agree8", 1, 1, 0, 5'b00000, 0, 2'b00);
`else
        chk_out("agree8", 1, 1, 0, 5'b10000, 0, 2'b01);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
